// File: rtl/tpu_tile_sequencer_if.sv
// Host/datapath bundle for the TPU tile sequencer.
// master = host side (drives start/abort/config), slave = the sequencer (drives strobes/addresses).
interface tpu_tile_sequencer_if #(
    parameter int ADDRESSSIZE   = 10,
    parameter int ADDRESSSIZE_W = 2,
    parameter int TILE_BW       = 4
);
    logic                     start;
    logic                     abort;
    logic [TILE_BW-1:0]       num_tiles;
    logic [ADDRESSSIZE-1:0]   ub_base;
    logic [ADDRESSSIZE-1:0]   res_base;
    logic [ADDRESSSIZE_W-1:0] w_base;
    logic                     busy;
    logic                     done;
    logic                     ub_rd_en;
    logic [ADDRESSSIZE-1:0]   ub_rd_addr;
    logic [ADDRESSSIZE_W-1:0] w_addr;
    logic                     we_rl;
    logic                     res_wr_en;
    logic [ADDRESSSIZE-1:0]   res_wr_addr;
    logic [TILE_BW-1:0]       tile_idx;
    logic [31:0]              cycle_count;

    modport master (
        output start, abort, num_tiles, ub_base, res_base, w_base,
        input  busy, done, ub_rd_en, ub_rd_addr, w_addr, we_rl,
               res_wr_en, res_wr_addr, tile_idx, cycle_count
    );

    modport slave (
        input  start, abort, num_tiles, ub_base, res_base, w_base,
        output busy, done, ub_rd_en, ub_rd_addr, w_addr, we_rl,
               res_wr_en, res_wr_addr, tile_idx, cycle_count
    );
endinterface

// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer: per tile, weight select + reload, MATRIX_SIZE UB reads, delayed result writes.
// Optional busy-cycle counter enabled by defining TPU_SEQ_PERF_CNT_EN.
module tpu_tile_sequencer #(
    parameter int MATRIX_SIZE   = 16,
    parameter int ADDRESSSIZE   = 10,
    parameter int ADDRESSSIZE_W = 2,
    parameter int TILE_BW       = 4,
    parameter int RESULT_LAT    = 34
) (
    input  logic                 clk,
    input  logic                 rstn,
    tpu_tile_sequencer_if.slave  bus
);
    localparam int KW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(MATRIX_SIZE - 1);

    typedef enum logic [2:0] {IDLE, WADDR, WLOAD, STREAM, DRAIN, DONE} state_t;

    state_t                   state_q;
    logic [TILE_BW-1:0]       num_tiles_q;
    logic [ADDRESSSIZE-1:0]   ub_base_q;
    logic [ADDRESSSIZE-1:0]   res_base_q;
    logic [ADDRESSSIZE_W-1:0] w_base_q;
    logic [TILE_BW-1:0]       tile_idx_q;
    logic [KW-1:0]            k_q;
    logic [KW-1:0]            j_q;
    logic [RESULT_LAT-1:0]    line_q;
    logic                     wr_last_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     ub_rd_en_q;
    logic [ADDRESSSIZE-1:0]   ub_rd_addr_q;
    logic [ADDRESSSIZE_W-1:0] w_addr_q;
    logic                     we_rl_q;
    logic [ADDRESSSIZE-1:0]   res_wr_addr_q;

    logic [RESULT_LAT:0]      tap_d;
    logic                     wr_next_d;
    logic [ADDRESSSIZE-1:0]   tile_ofs_d;
    logic [TILE_BW:0]         tile_nxt_d;

    // tap_d[i] is the read strobe delayed by i cycles; the top tap is the write strobe.
    assign tap_d      = {line_q, ub_rd_en_q};
    assign wr_next_d  = tap_d[RESULT_LAT-1];
    assign tile_ofs_d = ADDRESSSIZE'(tile_idx_q) * ADDRESSSIZE'(MATRIX_SIZE);
    assign tile_nxt_d = {1'b0, tile_idx_q} + (TILE_BW+1)'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            num_tiles_q   <= '0;
            ub_base_q     <= '0;
            res_base_q    <= '0;
            w_base_q      <= '0;
            tile_idx_q    <= '0;
            k_q           <= '0;
            j_q           <= '0;
            line_q        <= '0;
            wr_last_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ub_rd_en_q    <= 1'b0;
            ub_rd_addr_q  <= '0;
            w_addr_q      <= '0;
            we_rl_q       <= 1'b0;
            res_wr_addr_q <= '0;
        end else if (bus.abort) begin
            state_q    <= IDLE;
            tile_idx_q <= '0;
            k_q        <= '0;
            j_q        <= '0;
            line_q     <= '0;
            wr_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ub_rd_en_q <= 1'b0;
            we_rl_q    <= 1'b0;
        end else begin
            line_q <= tap_d[RESULT_LAT-1:0];
            // Write address is set one cycle ahead so it lines up with the write strobe.
            if (wr_next_d) begin
                res_wr_addr_q <= res_base_q + tile_ofs_d + ADDRESSSIZE'(j_q);
                wr_last_q     <= (j_q == K_LAST);
                j_q           <= (j_q == K_LAST) ? '0 : j_q + KW'(1);
            end else begin
                wr_last_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        num_tiles_q <= bus.num_tiles;
                        ub_base_q   <= bus.ub_base;
                        res_base_q  <= bus.res_base;
                        w_base_q    <= bus.w_base;
                        tile_idx_q  <= '0;
                        busy_q      <= 1'b1;
                        if (bus.num_tiles == '0) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            w_addr_q <= bus.w_base;
                            state_q  <= WADDR;
                        end
                    end
                end
                WADDR: begin
                    we_rl_q <= 1'b1;
                    state_q <= WLOAD;
                end
                WLOAD: begin
                    we_rl_q      <= 1'b0;
                    ub_rd_en_q   <= 1'b1;
                    ub_rd_addr_q <= ub_base_q + tile_ofs_d;
                    k_q          <= '0;
                    state_q      <= STREAM;
                end
                STREAM: begin
                    if (k_q == K_LAST) begin
                        ub_rd_en_q <= 1'b0;
                        state_q    <= DRAIN;
                    end else begin
                        k_q          <= k_q + KW'(1);
                        ub_rd_addr_q <= ub_rd_addr_q + ADDRESSSIZE'(1);
                    end
                end
                DRAIN: begin
                    if (tap_d[RESULT_LAT] && wr_last_q) begin
                        if (tile_nxt_d < {1'b0, num_tiles_q}) begin
                            tile_idx_q <= tile_nxt_d[TILE_BW-1:0];
                            w_addr_q   <= w_base_q + ADDRESSSIZE_W'(tile_nxt_d);
                            state_q    <= WADDR;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.ub_rd_en    = ub_rd_en_q;
    assign bus.ub_rd_addr  = ub_rd_addr_q;
    assign bus.w_addr      = w_addr_q;
    assign bus.we_rl       = we_rl_q;
    assign bus.res_wr_en   = tap_d[RESULT_LAT];
    assign bus.res_wr_addr = res_wr_addr_q;
    assign bus.tile_idx    = tile_idx_q;

`ifdef TPU_SEQ_PERF_CNT_EN
    logic [31:0] cycle_count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_count_q <= '0;
        end else if (bus.abort) begin
            cycle_count_q <= cycle_count_q;
        end else if (state_q == IDLE && bus.start) begin
            cycle_count_q <= '0;
        end else if (busy_q && cycle_count_q != 32'hFFFF_FFFF) begin
            cycle_count_q <= cycle_count_q + 32'd1;
        end
    end

    assign bus.cycle_count = cycle_count_q;
`else
    assign bus.cycle_count = 32'd0;
`endif
endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Directed bench for tpu_tile_sequencer with MATRIX_SIZE=4, RESULT_LAT=6.
// Each run records per-cycle strobes as bit masks (bit c = cycle c, cycle 0 carries start).
module tb_tpu_tile_sequencer;
  localparam int MS  = 4;
  localparam int LAT = 6;
  localparam int AW  = 10;
  localparam int WW  = 2;
  localparam int TB  = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  tpu_tile_sequencer_if #(.ADDRESSSIZE(AW), .ADDRESSSIZE_W(WW), .TILE_BW(TB)) bus ();

  tpu_tile_sequencer #(
    .MATRIX_SIZE(MS), .ADDRESSSIZE(AW), .ADDRESSSIZE_W(WW), .TILE_BW(TB), .RESULT_LAT(LAT)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [63:0]   rd_m, wr_m, we_m, done_m, busy_m;
  logic [AW-1:0] rd_a [64];
  logic [AW-1:0] wr_a [64];
  logic [WW-1:0] wa   [64];
  logic [TB-1:0] ti   [64];
  logic [31:0]   exp_cc25, exp_cc13;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [TB-1:0] nt, input logic [AW-1:0] ub,
                         input logic [AW-1:0] rb, input logic [WW-1:0] wb);
    bus.num_tiles = nt;
    bus.ub_base   = ub;
    bus.res_base  = rb;
    bus.w_base    = wb;
  endtask

  // Called at a negedge with the DUT idle; runs n cycles, sampling each at its negedge.
  task automatic run(input int n, input int abort_at, input int restart_at, input bit alt);
    rd_m = '0; wr_m = '0; we_m = '0; done_m = '0; busy_m = '0;
    for (int c = 0; c < n; c++) begin
      rd_m[c]   = bus.ub_rd_en;
      wr_m[c]   = bus.res_wr_en;
      we_m[c]   = bus.we_rl;
      done_m[c] = bus.done;
      busy_m[c] = bus.busy;
      rd_a[c]   = bus.ub_rd_addr;
      wr_a[c]   = bus.res_wr_addr;
      wa[c]     = bus.w_addr;
      ti[c]     = bus.tile_idx;
      bus.start = (c == 0) || (c == restart_at);
      bus.abort = (c == abort_at);
      if (c == restart_at && alt) set_cfg(4'd3, 10'h200, 10'h050, 2'd2);
      @(posedge clk);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
`ifdef TPU_SEQ_PERF_CNT_EN
    exp_cc25 = 32'd25;
    exp_cc13 = 32'd13;
`else
    exp_cc25 = 32'd0;
    exp_cc13 = 32'd0;
`endif
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg(4'd1, 10'h010, 10'h100, 2'd1);
    repeat (3) @(negedge clk);
    check("reset_busy",   {63'd0, bus.busy}, 64'd0);
    check("reset_rd_en",  {63'd0, bus.ub_rd_en}, 64'd0);
    check("reset_rd_addr", {54'd0, bus.ub_rd_addr}, 64'd0);
    check("reset_w_addr", {62'd0, bus.w_addr}, 64'd0);
    check("reset_cc",     {32'd0, bus.cycle_count}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single tile
    run(16, -1, -1, 1'b0);
    check("t1_we_mask",   we_m,   64'h4);
    check("t1_w_addr",    {62'd0, wa[2]}, 64'd1);
    check("t1_rd_mask",   rd_m,   64'h78);
    check("t1_rd_first",  {54'd0, rd_a[3]}, 64'h010);
    check("t1_rd_last",   {54'd0, rd_a[6]}, 64'h013);
    check("t1_rd_hold",   {54'd0, rd_a[7]}, 64'h013);
    check("t1_wr_mask",   wr_m,   64'h1E00);
    check("t1_wr_first",  {54'd0, wr_a[9]}, 64'h100);
    check("t1_wr_last",   {54'd0, wr_a[12]}, 64'h103);
    check("t1_done_mask", done_m, 64'h2000);
    check("t1_busy_mask", busy_m, 64'h3FFE);

    // Two tiles
    set_cfg(4'd2, 10'h010, 10'h100, 2'd1);
    run(28, -1, -1, 1'b0);
    check("t2_we_mask",   we_m,   64'h4004);
    check("t2_w_addr1",   {62'd0, wa[14]}, 64'd2);
    check("t2_tile_idx",  {60'd0, ti[15]}, 64'd1);
    check("t2_rd_mask",   rd_m,   64'h78078);
    check("t2_rd_t1_first", {54'd0, rd_a[15]}, 64'h014);
    check("t2_rd_t1_last",  {54'd0, rd_a[18]}, 64'h017);
    check("t2_wr_mask",   wr_m,   64'h1E01E00);
    check("t2_wr_t1_first", {54'd0, wr_a[21]}, 64'h104);
    check("t2_wr_t1_last",  {54'd0, wr_a[24]}, 64'h107);
    check("t2_done_mask", done_m, 64'h2000000);
    check("t2_busy_mask", busy_m, 64'h3FFFFFE);
    check("t2_cycle_count", {32'd0, bus.cycle_count}, {32'd0, exp_cc25});

    // Address wrap
    set_cfg(4'd2, 10'h3FE, 10'h3FF, 2'd3);
    run(28, -1, -1, 1'b0);
    check("wrap_w_addr0", {62'd0, wa[2]},  64'd3);
    check("wrap_rd3",     {54'd0, rd_a[3]}, 64'h3FE);
    check("wrap_rd4",     {54'd0, rd_a[4]}, 64'h3FF);
    check("wrap_rd5",     {54'd0, rd_a[5]}, 64'h000);
    check("wrap_rd6",     {54'd0, rd_a[6]}, 64'h001);
    check("wrap_wr9",     {54'd0, wr_a[9]}, 64'h3FF);
    check("wrap_wr10",    {54'd0, wr_a[10]}, 64'h000);
    check("wrap_w_addr1", {62'd0, wa[14]}, 64'd0);

    // Zero tiles
    set_cfg(4'd0, 10'h010, 10'h100, 2'd1);
    run(4, -1, -1, 1'b0);
    check("z_done_mask", done_m, 64'h2);
    check("z_busy_mask", busy_m, 64'h2);
    check("z_strobes",   rd_m | wr_m | we_m, 64'h0);

    // Abort at cycle 8, restart at cycle 10
    set_cfg(4'd1, 10'h010, 10'h100, 2'd1);
    run(26, 8, 10, 1'b0);
    check("ab_busy_c9",   {63'd0, busy_m[9]}, 64'd0);
    check("ab_rd_mask",   rd_m,   64'h1E078);
    check("ab_wr_mask",   wr_m,   64'h780000);
    check("ab_done_mask", done_m, 64'h800000);
    check("ab_cycle_count", {32'd0, bus.cycle_count}, {32'd0, exp_cc13});

    // start re-pulsed mid-run with different inputs
    set_cfg(4'd1, 10'h010, 10'h100, 2'd1);
    run(16, -1, 5, 1'b1);
    check("rp_rd_mask",   rd_m,   64'h78);
    check("rp_rd_last",   {54'd0, rd_a[6]}, 64'h013);
    check("rp_wr_mask",   wr_m,   64'h1E00);
    check("rp_wr_last",   {54'd0, wr_a[12]}, 64'h103);
    check("rp_w_addr",    {62'd0, wa[12]}, 64'd1);
    check("rp_done_mask", done_m, 64'h2000);

    // Asynchronous reset in the middle of a run
    set_cfg(4'd2, 10'h010, 10'h100, 2'd1);
    run(10, -1, -1, 1'b0);
    check("ar_busy_before", {63'd0, bus.busy}, 64'd1);
    rstn = 1'b0;
    #1;
    check("ar_busy",  {63'd0, bus.busy}, 64'd0);
    check("ar_wr_en", {63'd0, bus.res_wr_en}, 64'd0);
    check("ar_tile",  {60'd0, bus.tile_idx}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    set_cfg(4'd1, 10'h010, 10'h100, 2'd1);
    run(16, -1, -1, 1'b0);
    check("ar_rerun_wr_mask",   wr_m,   64'h1E00);
    check("ar_rerun_done_mask", done_m, 64'h2000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tpu_tile_sequencer.md
Name: tpu_tile_sequencer

Overview:
Parametrised tile sequencer for the TPU top level. It replaces the fixed 5-bit result counter, the standalone state counter and the externally driven valid_address / we_rl strobes. For each of N tiles it:
- selects a weight set and pulses weight reload,
- streams MATRIX_SIZE activation rows out of the unified buffer,
- writes MATRIX_SIZE result rows into the result SRAM a fixed pipeline latency later.
It sits between the host start/done handshake and the UB, weight SRAM, systolic array and result SRAM.

Parameters:
MATRIX_SIZE, 16, rows per tile; UB reads and result writes per tile.
ADDRESSSIZE, 10, UB and result SRAM address width.
ADDRESSSIZE_W, 2, weight SRAM address width.
TILE_BW, 4, width of tile count; max 2^TILE_BW-1 tiles per run.
RESULT_LAT, 34, cycles from a UB read-enable cycle to the matching result write-enable cycle (>=1).

Ports:
clk  in  1  clock.
rstn  in  1  reset.
start  in  1  run request; sampled only in IDLE.
abort  in  1  synchronous abort; priority over start.
num_tiles  in  TILE_BW  tile count, latched on accepted start.
ub_base  in  ADDRESSSIZE  first UB address, latched on start.
res_base  in  ADDRESSSIZE  first result address, latched on start.
w_base  in  ADDRESSSIZE_W  weight address of tile 0, latched on start.
busy  out  1  high in every non-IDLE state.
done  out  1  one-cycle pulse at run completion.
ub_rd_en  out  1  UB read strobe.
ub_rd_addr  out  ADDRESSSIZE  UB read address.
w_addr  out  ADDRESSSIZE_W  weight SRAM address.
we_rl  out  1  weight reload strobe to the systolic array.
res_wr_en  out  1  result SRAM write strobe.
res_wr_addr  out  ADDRESSSIZE  result write address.
tile_idx  out  TILE_BW  index of the tile in progress.
cycle_count  out  32  busy-cycle counter (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low. In reset all outputs and internal registers are 0 and the state is IDLE.
- States: IDLE, WADDR, WLOAD, STREAM, DRAIN, DONE.
- IDLE: when start=1 and abort=0, latch the inputs and clear tile_idx.
  - num_tiles=0: go to DONE.
  - otherwise: go to WADDR.
- WADDR (1 cycle): w_addr = w_base + tile_idx (mod 2^ADDRESSSIZE_W), held for the whole tile. Then WLOAD.
- WLOAD (1 cycle): we_rl=1, because the weight SRAM read is synchronous. Then STREAM.
- STREAM (MATRIX_SIZE cycles, k=0..MATRIX_SIZE-1):
  - ub_rd_en=1.
  - ub_rd_addr = ub_base + tile_idx*MATRIX_SIZE + k, mod 2^ADDRESSSIZE.
  - Then DRAIN.
- Result path: a RESULT_LAT-deep valid delay line asserts res_wr_en exactly RESULT_LAT cycles after each ub_rd_en cycle.
  - res_wr_addr = res_base + tile_idx*MATRIX_SIZE + j, where j is the internal write counter 0..MATRIX_SIZE-1; wraps mod 2^ADDRESSSIZE.
- DRAIN (RESULT_LAT cycles): exits on the cycle carrying the last write (j=MATRIX_SIZE-1).
  - If tile_idx+1 < latched num_tiles: increment tile_idx and go to WADDR.
  - Otherwise: go to DONE.
- Tile period: exactly 2+MATRIX_SIZE+RESULT_LAT cycles. Tiles do not overlap.
- DONE (1 cycle): done=1, then IDLE. busy is still 1 in DONE.
- Strobe rules:
  - ub_rd_en, we_rl, res_wr_en and done are 0 outside their stated states/cycles.
  - ub_rd_addr and res_wr_addr hold their last value when the strobe is low.
- start while busy: ignored; no relatch.
- abort=1 in any state:
  - next cycle is IDLE.
  - The delay line, write counter and tile_idx are cleared.
  - No further res_wr_en, no done pulse.
- Asynchronous reset mid-run: same end state as abort, taking effect immediately.

Optional Feature:
Macro TPU_SEQ_PERF_CNT_EN.
- Defined:
  - cycle_count clears to 0 on an accepted start.
  - It increments on every cycle busy=1, including DONE.
  - It freezes after done and saturates at 2^32-1.
  - abort freezes it at its current value.
- Undefined: cycle_count is tied to 0 and no counter flops exist.

Test Plan:
All scenarios use MATRIX_SIZE=4, RESULT_LAT=6, ub_base=0x010, res_base=0x100, w_base=1, with start pulsed in cycle 0.
- Single tile (num_tiles=1):
  - we_rl at cycle 2, w_addr=1.
  - ub_rd_en cycles 3-6, addresses 0x010-0x013.
  - res_wr_en cycles 9-12, addresses 0x100-0x103.
  - done at cycle 13; busy cycles 1-13.
- Two tiles (num_tiles=2):
  - Tile 1: w_addr=2, we_rl at cycle 14, reads 0x014-0x017 at cycles 15-18, writes 0x104-0x107 at cycles 21-24.
  - done at cycle 25; cycle_count=25 with the macro, 0 without.
- Address wrap: ub_base=0x3FE, res_base=0x3FF, w_base=3, num_tiles=2.
  - UB reads 0x3FE,0x3FF,0x000,0x001 in tile 0.
  - Result writes start at 0x3FF then 0x000.
  - Tile 1 w_addr=0.
- num_tiles=0: done at cycle 1, busy only in cycle 1, no ub_rd_en, we_rl or res_wr_en.
- Abort at cycle 8 (num_tiles=1):
  - State is IDLE at cycle 9.
  - res_wr_en never asserts; done never asserts.
  - A new start at cycle 10 runs cleanly: done at cycle 23.
- start re-pulsed at cycle 5 during a run, with different inputs: ignored. Addresses and timing are identical to the single-tile scenario.
